ddr3_stream_ctrl: RTL and testbench
===================================

Name: ddr3_stream_ctrl

Overview:
- Parametrised DDR3 streaming sequencer between the host pipe (FrontPanel, okClk domain) and the MIG native app interface.
- Write mode: packs HOST_W host words into APP_W lines and issues line writes at consecutive addresses.
- Read mode: issues line reads with credit-based flow control, buffers the returned lines and unpacks them into HOST_W words for the pipe-out path.
- Supersedes the fixed 32->256 FIFO pair and the hard-wired address and count; base address, length and direction are set per transfer.

Parameters:
HOST_W, 32, host word width; APP_W must be an integer multiple of HOST_W
APP_W, 256, MIG app data width
ADDR_W, 29, app_addr width
LEN_W, 16, width of the line-count field
ADDR_INC, 8, app_addr increment per line (BL8)
RD_DEPTH, 4, read line buffer depth (power of 2, >=2); also the maximum number of outstanding reads

Ports:
clk  in  1  system clock (okClk); single clock domain
reset  in  1  synchronous, active-high
init_calib_complete  in  1  MIG calibration done
start  in  1  one-cycle transfer request
mode  in  1  0 = write to DDR3, 1 = read from DDR3; sampled on start
base_addr  in  ADDR_W  first line address; sampled on start
num_lines  in  LEN_W  number of APP_W lines; sampled on start
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at the end of a transfer
rd_overflow  out  1  sticky error flag; cleared by reset or an accepted start
in_data  in  HOST_W  host write word
in_valid  in  1  in_data valid
in_ready  out  1  block accepts in_data
out_data  out  HOST_W  host read word
out_valid  out  1  out_data valid
out_ready  in  1  host accepts out_data
app_addr  out  ADDR_W  MIG command address
app_cmd  out  3  3'b000 = write, 3'b001 = read
app_en  out  1  command valid
app_rdy  in  1  MIG accepts command
app_wdf_data  out  APP_W  write line
app_wdf_mask  out  APP_W/8  always 0
app_wdf_wren  out  1  write data valid
app_wdf_end  out  1  equals app_wdf_wren (one beat per line)
app_wdf_rdy  in  1  MIG accepts write data
app_rd_data  in  APP_W  read line
app_rd_data_valid  in  1  read line valid

Behaviour:
- Reset: state IDLE. All outputs 0: busy, done, rd_overflow, in_ready, out_valid, app_en, app_wdf_wren, app_wdf_end, app_addr, app_cmd, app_wdf_data, out_data. Pack and unpack counters, read buffer pointers and outstanding count are cleared.
- Reset mid-transfer aborts on the next edge. No command or data is completed afterwards.
- Word order is little-endian. Host word k of a line maps to bits [k*HOST_W +: HOST_W], k = 0..RATIO-1, where RATIO = APP_W/HOST_W.
- IDLE: start is accepted only if init_calib_complete=1. An accepted start latches mode, base_addr and num_lines and sets busy on the next cycle. start in any other state, or while calibration is incomplete, is ignored.
- num_lines=0: done pulses one cycle after start and busy never rises.
- Write path, state WR_FILL:
  - in_ready=1.
  - Each in_valid&in_ready stores one word at the current slot.
  - When the RATIO-th word is stored, go to WR_DATA. in_ready=0 in WR_DATA and WR_CMD.
- Write path, state WR_DATA:
  - app_wdf_wren=app_wdf_end=1 with the packed line; held stable until app_wdf_rdy.
  - On app_wdf_rdy, go to WR_CMD.
- Write path, state WR_CMD:
  - app_en=1, app_cmd=000, app_addr=current address; held until app_rdy.
  - On app_rdy: address += ADDR_INC (wraps modulo 2^ADDR_W), lines_left -= 1.
  - Then go to WR_FILL if lines_left != 0; otherwise go to IDLE with done for one cycle.
- Read path, state RD_RUN:
  - Issue: app_en=1, app_cmd=001 while issued<num_lines and (outstanding + buffer occupancy) < RD_DEPTH. On app_rdy: address += ADDR_INC, issued += 1, outstanding += 1.
  - Return: each app_rd_data_valid writes the line to the buffer and decrements outstanding.
  - Simultaneous issue acceptance and return leave outstanding unchanged.
  - A return while the buffer is full is dropped and sets rd_overflow.
  - Unpack: out_valid=1 whenever the buffer is non-empty. out_data is word slot k of the head line.
  - On out_valid&out_ready, k increments. After slot RATIO-1, the head line is popped and k returns to 0.
  - Completes when all lines are issued, outstanding=0 and the buffer is empty: go to IDLE and pulse done.
- Read latency: the first out_valid is asserted one cycle after the first app_rd_data_valid.
- Word throughput is one host word per cycle when out_ready=1.
- busy=1 in every state except IDLE. It falls in the same cycle that done pulses.

Test Plan:
1. Write, base 0x100, num_lines=2, host words 0..15, app_rdy/app_wdf_rdy held 1 -> two wdf beats {words 7..0}, {words 15..8}; commands at 0x100 and 0x108 with app_cmd=0; then a done pulse.
2. Write with app_wdf_rdy low 5 cycles and app_rdy low 3 cycles -> wren and line data stay stable; in_ready=0 until the command is accepted; exactly 1 line is written.
3. Read, num_lines=6, MIG latency 20 cycles, out_ready=1 -> at most 4 reads outstanding; 48 words out in order, line0 word0 = bits[31:0]; a done pulse.
4. Read with out_ready held 0 for 100 cycles -> issue stalls at 4 lines; rd_overflow stays 0; all data delivered after release.
5. Start with init_calib_complete=0; start with num_lines=0 -> the first is ignored with no done; the second pulses done next cycle with no app_en.
6. Reset asserted mid-read, base_addr=0x1FFFFFF8 -> all outputs 0 next cycle; a new transfer from 0x1FFFFFF8 wraps its next address to 0x0.

Source files
------------

// File: rtl/ddr3_stream_ctrl.sv
// DDR3 streaming sequencer: packs host words into MIG line writes, or issues
// credit-limited line reads and unpacks the returned lines into host words.
module ddr3_stream_ctrl #(
  parameter int HOST_W   = 32,
  parameter int APP_W    = 256,
  parameter int ADDR_W   = 29,
  parameter int LEN_W    = 16,
  parameter int ADDR_INC = 8,
  parameter int RD_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init_calib_complete,
  input  logic                start,
  input  logic                mode,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [LEN_W-1:0]    num_lines,
  output logic                busy,
  output logic                done,
  output logic                rd_overflow,
  input  logic [HOST_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [HOST_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_W-1:0]   app_addr,
  output logic [2:0]          app_cmd,
  output logic                app_en,
  input  logic                app_rdy,
  output logic [APP_W-1:0]    app_wdf_data,
  output logic [APP_W/8-1:0]  app_wdf_mask,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  input  logic                app_wdf_rdy,
  input  logic [APP_W-1:0]    app_rd_data,
  input  logic                app_rd_data_valid,
  output logic [2:0]          o_dbg_state
);

  localparam int RATIO = APP_W / HOST_W;
  localparam int SW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int PW    = $clog2(RD_DEPTH);
  localparam logic [SW-1:0]     LAST = SW'(RATIO - 1);
  localparam logic [ADDR_W-1:0] INC  = ADDR_W'(ADDR_INC);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_FILL = 3'd1,
    S_WR_DATA = 3'd2,
    S_WR_CMD  = 3'd3,
    S_RD_RUN  = 3'd4
  } state_t;

  state_t              r_state, w_next;
  logic                r_done, r_ovf;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_lines;
  logic [LEN_W-1:0]    r_issued;
  logic [PW:0]         r_outst;
  logic [PW:0]         r_wptr, r_rptr;
  logic [SW-1:0]       r_slot, r_kslot;
  logic [APP_W-1:0]    r_line;
  logic [APP_W-1:0]    r_buf [RD_DEPTH];

  logic                w_start_acc, w_done_set, w_issue_req;
  logic                w_wr_acc, w_wcmd_acc, w_iss, w_ret, w_push, w_pop, w_full;
  logic [PW:0]         w_occ;
  logic [PW+1:0]       w_credit;
  logic [APP_W-1:0]    w_head;

  // A transfer on any channel happens on a rising edge where its valid
  // (in_valid, out_valid, app_en, app_wdf_wren) and matching ready are both 1;
  // the valid side holds its payload stable until that edge.
  assign w_occ    = r_wptr - r_rptr;
  assign w_credit = {1'b0, r_outst} + {1'b0, w_occ};
  assign w_full   = (w_occ == (PW+1)'(RD_DEPTH));

  always_comb begin
    w_next      = r_state;
    w_start_acc = 1'b0;
    w_done_set  = 1'b0;
    w_issue_req = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && init_calib_complete) begin
          w_start_acc = 1'b1;
          if (num_lines == '0) w_done_set = 1'b1;
          else                 w_next = mode ? S_RD_RUN : S_WR_FILL;
        end
      end
      S_WR_FILL: if (in_valid && (r_slot == LAST)) w_next = S_WR_DATA;
      S_WR_DATA: if (app_wdf_rdy) w_next = S_WR_CMD;
      S_WR_CMD: begin
        if (app_rdy) begin
          if (r_lines == LEN_W'(1)) begin
            w_next     = S_IDLE;
            w_done_set = 1'b1;
          end else begin
            w_next = S_WR_FILL;
          end
        end
      end
      S_RD_RUN: begin
        // Credits cover both in-flight reads and lines already buffered.
        w_issue_req = (r_issued != r_lines) && (w_credit < (PW+2)'(RD_DEPTH));
        if ((r_issued == r_lines) && (r_outst == '0) && (w_occ == '0)) begin
          w_next     = S_IDLE;
          w_done_set = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_wr_acc   = (r_state == S_WR_FILL) && in_valid;
  assign w_wcmd_acc = (r_state == S_WR_CMD) && app_rdy;
  assign w_iss      = w_issue_req && app_rdy;
  assign w_ret      = (r_state == S_RD_RUN) && app_rd_data_valid;
  assign w_push     = w_ret && !w_full;
  assign w_pop      = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_addr   <= '0;
      r_lines  <= '0;
      r_issued <= '0;
      r_outst  <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_slot   <= '0;
      r_kslot  <= '0;
      r_line   <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done_set;
      if (w_start_acc) begin
        r_addr   <= base_addr;
        r_lines  <= num_lines;
        r_issued <= '0;
        r_ovf    <= 1'b0;
        r_slot   <= '0;
        r_kslot  <= '0;
      end
      if (w_wr_acc) begin
        r_line[r_slot*HOST_W +: HOST_W] <= in_data;
        r_slot <= (r_slot == LAST) ? '0 : r_slot + 1'b1;
      end
      if (w_wcmd_acc) begin
        r_addr  <= r_addr + INC;
        r_lines <= r_lines - 1'b1;
      end
      if (w_iss) begin
        r_addr   <= r_addr + INC;
        r_issued <= r_issued + 1'b1;
      end
      if (w_iss && !w_ret)                      r_outst <= r_outst + 1'b1;
      else if (!w_iss && w_ret && r_outst != '0) r_outst <= r_outst - 1'b1;
      if (w_ret) begin
        if (w_full) r_ovf  <= 1'b1;
        else        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        if (r_kslot == LAST) begin
          r_kslot <= '0;
          r_rptr  <= r_rptr + 1'b1;
        end else begin
          r_kslot <= r_kslot + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_buf[r_wptr[PW-1:0]] <= app_rd_data;
  end

  assign w_head       = r_buf[r_rptr[PW-1:0]];
  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign rd_overflow  = r_ovf;
  assign in_ready     = (r_state == S_WR_FILL);
  assign out_valid    = (r_state == S_RD_RUN) && (w_occ != '0);
  assign out_data     = out_valid ? w_head[r_kslot*HOST_W +: HOST_W] : '0;
  assign app_addr     = r_addr;
  assign app_cmd      = (r_state == S_RD_RUN) ? 3'b001 : 3'b000;
  assign app_en       = (r_state == S_WR_CMD) || w_issue_req;
  assign app_wdf_data = r_line;
  assign app_wdf_mask = '0;
  assign app_wdf_wren = (r_state == S_WR_DATA);
  assign app_wdf_end  = (r_state == S_WR_DATA);
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_ddr3_stream_ctrl.sv
// Directed bench for ddr3_stream_ctrl: behavioural MIG with fixed read latency,
// scoreboard queues for commands, write lines and read words.
module tb_ddr3_stream_ctrl;
  localparam int LAT = 20;

  logic          clk = 1'b0;
  logic          reset, init_calib_complete, start, mode;
  logic [28:0]   base_addr;
  logic [15:0]   num_lines;
  logic          busy, done, rd_overflow;
  logic [31:0]   in_data;
  logic          in_valid, in_ready;
  logic [31:0]   out_data;
  logic          out_valid, out_ready;
  logic [28:0]   app_addr;
  logic [2:0]    app_cmd;
  logic          app_en, app_rdy;
  logic [255:0]  app_wdf_data;
  logic [31:0]   app_wdf_mask;
  logic          app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [255:0]  app_rd_data = '0;
  logic          app_rd_data_valid = 1'b0;
  logic [2:0]    o_dbg_state;

  ddr3_stream_ctrl dut (
    .clk(clk), .reset(reset), .init_calib_complete(init_calib_complete),
    .start(start), .mode(mode), .base_addr(base_addr), .num_lines(num_lines),
    .busy(busy), .done(done), .rd_overflow(rd_overflow),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .o_dbg_state(o_dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [31:0]  exp_q[$];
  logic [255:0] wline_q[$];
  logic [31:0]  cmd_q[$];
  int           due_q[$];
  logic [28:0]  raddr_q[$];
  int n_vec = 0, n_miss = 0;
  int done_cnt = 0, rd_cmds = 0, wr_cmds = 0, wr_beats = 0, en_cycles = 0;
  int outst = 0, max_out = 0, rd_words = 0;
  logic [31:0] first_word = '0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mig_word(input logic [28:0] a, input int k);
    return {a[27:0], 4'(k)};
  endfunction

  function automatic logic [255:0] mig_line(input logic [28:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = mig_word(a, k);
    return l;
  endfunction

  // monitors: sampled at negedge, i.e. the values the next posedge will consume
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        done_cnt++;
        check("done_busy", busy, 0);
      end
      if (app_en) en_cycles++;
      if (app_en && app_rdy) begin
        if (cmd_q.size() == 0) check("cmd_extra", 1, 0);
        else                   check("cmd", {app_cmd, app_addr}, cmd_q.pop_front());
        if (app_cmd == 3'b001) begin
          rd_cmds++;
          due_q.push_back(cyc + LAT);
          raddr_q.push_back(app_addr);
        end else begin
          wr_cmds++;
        end
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        wr_beats++;
        check("wdf_end", app_wdf_end, 1);
        check("wdf_mask", app_wdf_mask, 0);
        if (wline_q.size() == 0) check("wdf_extra", 1, 0);
        else                     check("wdf_line", app_wdf_data, wline_q.pop_front());
      end
      outst = outst + ((app_en && app_rdy && app_cmd == 3'b001) ? 1 : 0)
                    - (app_rd_data_valid ? 1 : 0);
      if (outst > max_out) max_out = outst;
      if (out_valid && out_ready) begin
        if (rd_words == 0) first_word = out_data;
        rd_words++;
        if (exp_q.size() == 0) check("rd_extra", 1, 0);
        else                   check("rd_word", out_data, exp_q.pop_front());
      end
    end
  end

  // MIG read-return driver
  always @(posedge clk) begin
    #1;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      app_rd_data_valid = 1'b1;
      app_rd_data       = mig_line(raddr_q.pop_front());
      void'(due_q.pop_front());
    end else begin
      app_rd_data_valid = 1'b0;
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic m, input logic [28:0] b, input logic [15:0] n);
    start = 1'b1; mode = m; base_addr = b; num_lines = n;
    step(1);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    int t = 0;
    in_valid = 1'b1;
    in_data  = w;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) begin
        check("in_timeout", 1, 0);
        break;
      end
    end
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int d0 = done_cnt;
    int t  = 0;
    while (done_cnt == d0 && t < limit) begin
      @(posedge clk);
      t++;
    end
    #1;
    check(tag, done_cnt - d0, 1);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_ctl"}, {busy, done, rd_overflow, in_ready, out_valid,
                          app_en, app_wdf_wren, app_wdf_end}, 0);
    check({tag, "_addr"}, app_addr, 0);
    check({tag, "_cmd"}, app_cmd, 0);
    check({tag, "_wdata"}, app_wdf_data, 0);
    check({tag, "_odata"}, out_data, 0);
    check({tag, "_state"}, o_dbg_state, 0);
  endtask

  task automatic expect_read(input logic [28:0] b, input int n);
    logic [28:0] a;
    for (int i = 0; i < n; i++) begin
      a = b + 29'(8 * i);
      cmd_q.push_back({3'b001, a});
      for (int k = 0; k < 8; k++) exp_q.push_back(mig_word(a, k));
    end
  endtask

  initial begin
    #300000;
    check("watchdog", 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b0, c0, d0, e0;
    logic [31:0] w0;
    logic [255:0] l0;
    reset = 1'b1; init_calib_complete = 1'b1; start = 1'b0; mode = 1'b0;
    base_addr = '0; num_lines = '0; in_data = '0; in_valid = 1'b0;
    out_ready = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    step(3);
    check_idle_zero("rst");
    reset = 1'b0;
    step(2);

    // 1: two-line write, MIG always ready
    cmd_q.push_back({3'b000, 29'h100});
    cmd_q.push_back({3'b000, 29'h108});
    wline_q.push_back(256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000);
    wline_q.push_back(256'h0000000f_0000000e_0000000d_0000000c_0000000b_0000000a_00000009_00000008);
    b0 = wr_beats;
    do_start(1'b0, 29'h100, 16'd2);
    check("t1_busy", busy, 1);
    for (int w = 0; w < 16; w++) send_word(32'(w));
    wait_done("t1_done", 50);
    check("t1_beats", wr_beats - b0, 2);
    check("t1_cmdq", cmd_q.size(), 0);

    // 2: one-line write with wdf and cmd back-pressure
    app_wdf_rdy = 1'b0;
    app_rdy     = 1'b0;
    l0 = 256'hc0de0007_c0de0006_c0de0005_c0de0004_c0de0003_c0de0002_c0de0001_c0de0000;
    cmd_q.push_back({3'b000, 29'h4000});
    wline_q.push_back(l0);
    b0 = wr_beats; c0 = wr_cmds;
    do_start(1'b0, 29'h4000, 16'd1);
    for (int w = 0; w < 8; w++) send_word(32'hc0de_0000 + 32'(w));
    repeat (5) begin
      @(negedge clk);
      check("t2_wren", app_wdf_wren, 1);
      check("t2_wdata", app_wdf_data, l0);
      check("t2_inrdy_d", in_ready, 0);
    end
    step(1);
    app_wdf_rdy = 1'b1;
    step(1);
    app_wdf_rdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t2_en", app_en, 1);
      check("t2_addr", app_addr, 29'h4000);
      check("t2_inrdy_c", in_ready, 0);
    end
    step(1);
    app_rdy = 1'b1;
    wait_done("t2_done", 20);
    app_wdf_rdy = 1'b1;
    check("t2_beats", wr_beats - b0, 1);
    check("t2_cmds", wr_cmds - c0, 1);

    // 3: six-line read, latency LAT, host always ready
    expect_read(29'h200, 6);
    max_out = 0; rd_words = 0;
    do_start(1'b1, 29'h200, 16'd6);
    wait_done("t3_done", 600);
    check("t3_words", rd_words, 48);
    check("t3_w0", first_word, 32'h0000_2000);
    check("t3_maxout", max_out, 4);
    check("t3_ovf", rd_overflow, 0);
    check("t3_expq", exp_q.size(), 0);

    // 4: host stalled for 100 cycles
    expect_read(29'h800, 6);
    out_ready = 1'b0;
    c0 = rd_cmds;
    do_start(1'b1, 29'h800, 16'd6);
    step(100);
    check("t4_issued", rd_cmds - c0, 4);
    check("t4_oval", out_valid, 1);
    check("t4_ovf", rd_overflow, 0);
    out_ready = 1'b1;
    wait_done("t4_done", 600);
    check("t4_issued_all", rd_cmds - c0, 6);
    check("t4_ovf_end", rd_overflow, 0);
    check("t4_expq", exp_q.size(), 0);

    // 5: start without calibration, then zero-length start
    init_calib_complete = 1'b0;
    d0 = done_cnt; e0 = en_cycles;
    do_start(1'b0, 29'h0, 16'd2);
    step(3);
    check("t5_nocal_busy", busy, 0);
    check("t5_nocal_done", done_cnt - d0, 0);
    init_calib_complete = 1'b1;
    do_start(1'b1, 29'h0, 16'd0);
    check("t5_zero_done", done, 1);
    check("t5_zero_busy", busy, 0);
    step(1);
    check("t5_zero_pulse", done, 0);
    check("t5_zero_en", en_cycles - e0, 0);
    check("t5_zero_cnt", done_cnt - d0, 1);

    // 6: reset mid-read, then a read that wraps the address
    expect_read(29'h1fff_fff8, 6);
    do_start(1'b1, 29'h1fff_fff8, 16'd6);
    step(10);
    reset = 1'b1;
    step(1);
    check_idle_zero("t6_rst");
    cmd_q.delete(); exp_q.delete(); due_q.delete(); raddr_q.delete();
    outst = 0;
    step(1);
    reset = 1'b0;
    step(30);
    check("t6_idle", busy, 0);
    cmd_q.push_back({3'b001, 29'h1fff_fff8});
    cmd_q.push_back({3'b001, 29'h0});
    w0 = mig_word(29'h1fff_fff8, 0);
    for (int k = 0; k < 8; k++) exp_q.push_back(mig_word(29'h1fff_fff8, k));
    for (int k = 0; k < 8; k++) exp_q.push_back(mig_word(29'h0, k));
    rd_words = 0;
    do_start(1'b1, 29'h1fff_fff8, 16'd2);
    wait_done("t6_done", 300);
    check("t6_w0", first_word, w0);
    check("t6_cmdq", cmd_q.size(), 0);
    check("t6_expq", exp_q.size(), 0);

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
